// File: rtl/buffer_reader_if.sv
// Buffer-side and stream-side signals of buffer_reader, bundled as one interface.
//
// Handshake rules:
//  - Buffer side: a pop happens on a rising edge where buf_read_enable=1. The
//    reader raises it only while buf_valid=1 and captures buf_dout on that edge.
//    buf_empty is a status flag only and is never used to decide a transfer.
//  - Stream side: an element transfers on a rising edge where out_valid=1 and
//    out_ready=1. While out_valid=1 and out_ready=0, out_data and out_last stay
//    stable until the transfer completes.
// The master modport is the reader. The slave modport is the environment that
// drives the buffer and consumes the stream.
interface buffer_reader_if #(
  parameter int ROW_SIZE = 8,
  parameter int PAR_READ = 4
);
  logic                         buf_valid;
  logic                         buf_empty;
  logic [ROW_SIZE*PAR_READ-1:0] buf_dout;
  logic                         buf_read_enable;
  logic [ROW_SIZE-1:0]          out_data;
  logic                         out_valid;
  logic                         out_ready;
  logic                         out_last;

  modport master (
    input  buf_valid, buf_empty, buf_dout, out_ready,
    output buf_read_enable, out_data, out_valid, out_last
  );

  modport slave (
    output buf_valid, buf_empty, buf_dout, out_ready,
    input  buf_read_enable, out_data, out_valid, out_last
  );
endinterface

// File: rtl/buffer_reader.sv
// buffer_reader: pops PAR_READ-element words from a circular buffer and
// serialises them one element per cycle, element 0 first. A new word is
// popped on the final-element handshake, so consecutive words stream with
// no bubble.
// Optional feature: define BUFFER_READER_ELEM_COUNT_EN to add the 16-bit
// elem_count output, which counts downstream handshakes.
module buffer_reader #(
  parameter int ROW_SIZE = 8,
  parameter int PAR_READ = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  buffer_reader_if.master        bus,
  output logic                   busy,
`ifdef BUFFER_READER_ELEM_COUNT_EN
  output logic [15:0]            elem_count,
`endif
  output logic                   state_dbg
);

  localparam int IDX_W = (PAR_READ > 1) ? $clog2(PAR_READ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAR_READ - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t                       state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [ROW_SIZE*PAR_READ-1:0] word_q, word_d;
  logic [ROW_SIZE-1:0]          elems [PAR_READ];

  logic                         rd_en;
  logic                         o_valid;
  logic                         o_last;
  logic [ROW_SIZE-1:0]          o_data;
  logic                         hs;
  logic                         unused_status;

  // buf_empty is status only; it is kept visible here so the port is not dangling.
  assign unused_status = bus.buf_empty;

  // Split the held word into elements; element k sits in bits [k*ROW_SIZE +: ROW_SIZE].
  always_comb begin
    for (int k = 0; k < PAR_READ; k++) begin
      elems[k] = word_q[k*ROW_SIZE +: ROW_SIZE];
    end
  end

  // Next-state, pop request and stream outputs. Reset blanks every output.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    rd_en   = 1'b0;
    o_valid = 1'b0;
    o_last  = 1'b0;
    o_data  = '0;
    case (state_q)
      S_IDLE: begin
        rd_en = bus.buf_valid;
        if (bus.buf_valid) begin
          state_d = S_SEND;
          idx_d   = '0;
          word_d  = bus.buf_dout;
        end
      end
      S_SEND: begin
        o_valid = 1'b1;
        o_data  = elems[idx_q];
        o_last  = (idx_q == LAST_IDX);
        if (bus.out_ready) begin
          if (idx_q != LAST_IDX) begin
            idx_d = idx_q + 1'b1;
          end else if (bus.buf_valid) begin
            // Reload on the final handshake so the next word follows immediately.
            rd_en  = 1'b1;
            word_d = bus.buf_dout;
            idx_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) begin
      rd_en   = 1'b0;
      o_valid = 1'b0;
      o_last  = 1'b0;
      o_data  = '0;
    end
  end

  assign hs                  = o_valid & bus.out_ready;
  assign bus.buf_read_enable = rd_en;
  assign bus.out_valid       = o_valid;
  assign bus.out_last        = o_last;
  assign bus.out_data        = o_data;
  assign busy                = (state_q == S_SEND) & ~rst;
  assign state_dbg           = state_q;

  // State, index and held-word registers. Reset drops any unsent elements.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
    end
  end

`ifdef BUFFER_READER_ELEM_COUNT_EN
  logic [15:0] count_q;

  // Handshake counter; wraps naturally from 0xFFFF to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (hs) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign elem_count = count_q;
`else
  logic unused_hs;
  assign unused_hs = hs;
`endif

endmodule

// File: doc/buffer_reader.md
BUFFER_READER -- requirements
Module: buffer_reader

Interface
REQ-001 Parameter ROW_SIZE, default 8: width in bits of one element.
REQ-002 Parameter PAR_READ, default 4: elements delivered by the circular buffer per read.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port buf_valid  input  1  buffer presents a valid PAR_READ-element word on buf_dout.
REQ-006 Port buf_empty  input  1  buffer empty flag; status only, not used for the transfer decision.
REQ-007 Port buf_dout  input  ROW_SIZE*PAR_READ  buffer read word; element k occupies bits [k*ROW_SIZE +: ROW_SIZE].
REQ-008 Port buf_read_enable  output  1  pop request to the buffer; combinational from state, buf_valid and out_ready.
REQ-009 Port out_data  output  ROW_SIZE  current serialized element.
REQ-010 Port out_valid  output  1  out_data valid.
REQ-011 Port out_ready  input  1  downstream accepts out_data.
REQ-012 Port out_last  output  1  out_data is element PAR_READ-1 of its word.
REQ-013 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM has two states: IDLE (no held word) and SEND (word held in shift register, index idx).
REQ-015 A buffer pop occurs on a cycle where buf_read_enable=1; the block captures buf_dout into the holding register on that same edge.
REQ-016 In IDLE, buf_read_enable = buf_valid; a pop moves the FSM to SEND with idx=0.
REQ-017 In SEND, out_valid=1, out_data = element idx of the held word, and out_last = (idx==PAR_READ-1).
REQ-018 A downstream handshake occurs when out_valid & out_ready; a handshake with idx<PAR_READ-1 increments idx.
REQ-019 A handshake with idx==PAR_READ-1 and buf_valid=1 asserts buf_read_enable, loads the new word, sets idx=0, and stays in SEND, giving no bubble between words.
REQ-020 A handshake with idx==PAR_READ-1 and buf_valid=0 returns the FSM to IDLE.
REQ-021 buf_read_enable is never asserted in SEND except on the final-element handshake.
REQ-022 When out_ready=0, out_data, idx and the held word stay stable, and no pop occurs.
REQ-023 Throughput is one element per cycle under continuous buf_valid and out_ready; the first element appears one cycle after the pop.
REQ-024 idx is ceil(log2(PAR_READ)) bits wide, minimum 1 bit; for PAR_READ=1 every handshake is a last handshake.
REQ-025 In IDLE, out_valid=0, out_last=0 and out_data=0.

Reset
REQ-026 rst=1 at a clock edge forces IDLE, idx=0, holding register=0 and element counter=0, overriding any pop or handshake in that cycle.
REQ-027 While rst=1, buf_read_enable=0, out_valid=0, out_last=0, out_data=0 and busy=0.
REQ-028 When reset is applied mid-word, the unsent elements are discarded and are not re-requested.

Configuration
REQ-029 Macro BUFFER_READER_ELEM_COUNT_EN, when defined, adds output port elem_count (16 bits) that increments by 1 on each downstream handshake, wraps from 0xFFFF to 0, and resets to 0.
REQ-030 When BUFFER_READER_ELEM_COUNT_EN is undefined, port elem_count and its counter are absent, and all other behaviour is identical.

Verification
REQ-031 Reset, then buf_valid=1 with buf_dout=0x44332211 and out_ready=1 held -> pop at cycle 0; out_data 0x11, 0x22, 0x33, 0x44 on cycles 1-4; out_last=1 only with 0x44.
REQ-032 Two words 0x44332211 then 0x88776655 presented back-to-back with out_ready=1 -> second pop on the 0x44 handshake cycle; 0x55 follows 0x44 with no gap; exactly 2 pops.
REQ-033 out_ready toggles 1,0,0,1,... during a word -> each element held stable while out_ready=0; order 0x11..0x44 preserved; no pop until the 0x44 handshake.
REQ-034 rst=1 asserted while 0x22 is presented -> next cycle out_valid=0 and busy=0; with buf_valid=0 after reset, no further output.
REQ-035 buf_valid=0 after the last element of a word is accepted -> IDLE, out_valid=0; buf_valid raised 3 cycles later -> pop the same cycle, first element on the next cycle.
REQ-036 With BUFFER_READER_ELEM_COUNT_EN defined, 3 words streamed -> elem_count=12; counter preloaded to 0xFFFF, then one handshake -> elem_count=0.
